// File: rtl/peripheral_fpmul.sv
// Multi-cycle IEEE-754 single-precision multiplier: shift-add mantissa product,
// round-to-nearest-even, denormals flushed to zero, uniform 28-cycle latency.
module peripheral_fpmul #(
  parameter int MULT_CYCLES = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic        busy,
  output logic        done,
  output logic [31:0] dataR,
  output logic [2:0]  flags
);

  localparam int CW = $clog2(MULT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_MULT, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [31:0]       a_reg, b_reg;
  logic              sign_reg, nan_reg, inf_reg, zero_reg;
  logic [23:0]       ma_reg;
  logic [47:0]       acc_reg;
  logic signed [9:0] exp_reg;
  logic [CW-1:0]     cnt_reg;
  logic [22:0]       mant_reg;
  logic              guard_reg, sticky_reg;
  logic              busy_reg, done_reg;
  logic [31:0]       data_r_reg;
  logic [2:0]        flags_reg;

  // Operand field decode
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic [23:0] ma, mb;
  assign ea = a_reg[30:23];
  assign eb = b_reg[30:23];
  assign fa = a_reg[22:0];
  assign fb = b_reg[22:0];
  assign ma = (ea == 8'h00) ? 24'h0 : {1'b1, fa};
  assign mb = (eb == 8'h00) ? 24'h0 : {1'b1, fb};

  logic nan_a, nan_b, inf_a, inf_b;
  assign nan_a = (ea == 8'hFF) && (fa != 23'h0);
  assign nan_b = (eb == 8'hFF) && (fb != 23'h0);
  assign inf_a = (ea == 8'hFF) && (fa == 23'h0);
  assign inf_b = (eb == 8'hFF) && (fb == 23'h0);

  // One shift-add step: add the multiplicand into the upper half when the
  // multiplier bit currently at the bottom of the accumulator is set.
  logic [24:0] step_sum;
  assign step_sum = {1'b0, acc_reg[47:24]} + (acc_reg[0] ? {1'b0, ma_reg} : 25'd0);

  logic [23:0] rounded;
  logic        round_inc;
  assign round_inc = guard_reg & (sticky_reg | mant_reg[0]);
  assign rounded   = {1'b0, mant_reg} + {23'h0, round_inc};

  logic [31:0] result_w;
  logic [2:0]  result_flags_w;
  always_comb begin
    result_w       = {sign_reg, exp_reg[7:0], mant_reg};
    result_flags_w = 3'b000;
    if (nan_reg || (inf_reg && zero_reg)) begin
      result_w       = 32'h7FC00000;
      result_flags_w = 3'b100;
    end else if (inf_reg) begin
      result_w = {sign_reg, 8'hFF, 23'h0};
    end else if (zero_reg) begin
      result_w = {sign_reg, 31'h0};
    end else if (exp_reg >= 10'sd255) begin
      result_w       = {sign_reg, 8'hFF, 23'h0};
      result_flags_w = 3'b010;
    end else if (exp_reg <= 10'sd0) begin
      result_w       = {sign_reg, 31'h0};
      result_flags_w = 3'b001;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_UNPACK;
      S_UNPACK: state_next = S_MULT;
      S_MULT:   if (cnt_reg == CW'(MULT_CYCLES - 1)) state_next = S_NORM;
      S_NORM:   state_next = S_ROUND;
      S_ROUND:  state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg      <= 32'h0;
      b_reg      <= 32'h0;
      sign_reg   <= 1'b0;
      nan_reg    <= 1'b0;
      inf_reg    <= 1'b0;
      zero_reg   <= 1'b0;
      ma_reg     <= 24'h0;
      acc_reg    <= 48'h0;
      exp_reg    <= 10'sd0;
      cnt_reg    <= '0;
      mant_reg   <= 23'h0;
      guard_reg  <= 1'b0;
      sticky_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      data_r_reg <= 32'h0;
      flags_reg  <= 3'b000;
    end else begin
      done_reg <= 1'b0;
      busy_reg <= (state_next == S_MULT) || (state_next == S_NORM) ||
                  (state_next == S_ROUND) || (state_next == S_DONE);
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            a_reg <= dataA;
            b_reg <= dataB;
          end
        end
        S_UNPACK: begin
          sign_reg <= a_reg[31] ^ b_reg[31];
          nan_reg  <= nan_a | nan_b;
          inf_reg  <= inf_a | inf_b;
          zero_reg <= (ea == 8'h00) | (eb == 8'h00);
          ma_reg   <= ma;
          acc_reg  <= {24'h0, mb};
          exp_reg  <= $signed({2'b00, ea} + {2'b00, eb} - 10'd127);
          cnt_reg  <= '0;
        end
        S_MULT: begin
          acc_reg <= {step_sum, acc_reg[23:1]};
          cnt_reg <= cnt_reg + CW'(1);
        end
        S_NORM: begin
          if (acc_reg[47]) begin
            mant_reg   <= acc_reg[46:24];
            guard_reg  <= acc_reg[23];
            sticky_reg <= |acc_reg[22:0];
            exp_reg    <= exp_reg + 10'sd1;
          end else begin
            mant_reg   <= acc_reg[45:23];
            guard_reg  <= acc_reg[22];
            sticky_reg <= |acc_reg[21:0];
          end
        end
        S_ROUND: begin
          // Carry out of the 23-bit field means the significand became 2.0
          if (rounded[23]) begin
            mant_reg <= 23'h0;
            exp_reg  <= exp_reg + 10'sd1;
          end else begin
            mant_reg <= rounded[22:0];
          end
        end
        S_DONE: begin
          data_r_reg <= result_w;
          flags_reg  <= result_flags_w;
          done_reg   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy  = busy_reg;
  assign done  = done_reg;
  assign dataR = data_r_reg;
  assign flags = flags_reg;

endmodule

// File: tb/tb_peripheral_fpmul.sv
// Bench for peripheral_fpmul: directed vector table, random operands against an
// integer-arithmetic reference model, and hand-written control sequences.
module tb_peripheral_fpmul;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dataA = 32'h0;
  logic [31:0] dataB = 32'h0;
  logic        busy, done;
  logic [31:0] dataR;
  logic [2:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;

  peripheral_fpmul #(.MULT_CYCLES(24)) dut (
    .clk(clk), .reset(reset), .start(start), .dataA(dataA), .dataB(dataB),
    .busy(busy), .done(done), .dataR(dataR), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [2:0]  f;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Reference: exact 48-bit integer product, then round-half-even by arithmetic.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    int ea, eb, e, s;
    longint unsigned fa, fb, p, q, rem, half;
    bit nan, inf, zer;
    sgn = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = longint'(a[22:0]);
    fb = longint'(b[22:0]);
    nan = (ea == 255 && fa != 0) || (eb == 255 && fb != 0);
    inf = (ea == 255) || (eb == 255);
    zer = (ea == 0) || (eb == 0);
    if (nan || (inf && zer)) return {3'b100, 32'h7FC00000};
    if (inf) return {3'b000, sgn, 8'hFF, 23'h0};
    if (zer) return {3'b000, sgn, 31'h0};
    p = (fa + 64'd8388608) * (fb + 64'd8388608);
    e = ea + eb - 127;
    if (p >= 64'd140737488355328) begin s = 24; e++; end
    else s = 23;
    q = p >> s;
    rem = p - (q << s);
    half = 64'd1 << (s - 1);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == 64'd16777216) begin q = 64'd8388608; e++; end
    if (e >= 255) return {3'b010, sgn, 8'hFF, 23'h0};
    if (e <= 0)   return {3'b001, sgn, 31'h0};
    return {3'b000, sgn, 8'(e), q[22:0]};
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [2:0] f,
                       output int lat, output int busy_cnt);
    @(negedge clk);
    dataA = a; dataB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; busy_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
      if (busy) busy_cnt++;
    end
    r = dataR; f = flags;
  endtask

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    logic [22:0] m;
    int sel;
    sel = int'($urandom_range(0, 9));
    m = 23'($urandom);
    case (sel)
      0: e = 8'h00;
      1: begin e = 8'hFF; if ($urandom_range(0, 1) == 0) m = 23'h0; end
      2: e = 8'($urandom_range(200, 254));
      3: e = 8'($urandom_range(1, 60));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, m};
  endfunction

  initial begin
    logic [31:0] r;
    logic [2:0]  f;
    logic [34:0] exp_v;
    int lat, bc, dones, first_done, second_done;

    vecs[0] = '{32'h3F800000, 32'hA1BE867D, 32'hA1BE867D, 3'b000};
    vecs[1] = '{32'h40000000, 32'hC2820000, 32'hC3020000, 3'b000};
    vecs[2] = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000};
    vecs[3] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 3'b000};
    vecs[4] = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010};
    vecs[5] = '{32'h00800000, 32'h00800000, 32'h00000000, 3'b001};
    vecs[6] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100};
    vecs[7] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000};
    vecs[8] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'b100};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_dataR", dataR, 32'h0);
    check("reset_flags", 32'(flags), 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Directed table
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, r, f, lat, bc);
      $display("vec %0d: %08h x %08h -> %08h flags %03b lat %0d busy %0d",
               i, vecs[i].a, vecs[i].b, r, f, lat, bc);
      check("vec_latency", 32'(lat), 32'd28);
      check("vec_busy_cycles", 32'(bc), 32'd27);
      check("vec_dataR", r, vecs[i].r);
      check("vec_flags", 32'(f), 32'(vecs[i].f));
    end

    // Random operands against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = rand_fp();
      b = rand_fp();
      exp_v = model(a, b);
      do_op(a, b, r, f, lat, bc);
      $display("rand %0d: %08h x %08h -> %08h flags %03b (model %08h %03b)",
               i, a, b, r, f, exp_v[31:0], exp_v[34:32]);
      check("rand_latency", 32'(lat), 32'd28);
      check("rand_dataR", r, exp_v[31:0]);
      check("rand_flags", 32'(f), 32'(exp_v[34:32]));
    end

    // Second start at cycle 5 ignored; operands changed at cycle 3 ignored
    @(negedge clk);
    dataA = 32'h40000000; dataB = 32'hC2820000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; first_done = -1;
    for (int k = 1; k <= 70; k++) begin
      if (k == 3) begin dataA = 32'h3F800000; dataB = 32'h3F800000; end
      start = (k == 4);  // sampled at edge 5
      @(posedge clk); #1;
      if (done) begin
        dones++;
        if (first_done < 0) begin first_done = k; r = dataR; f = flags; end
      end
    end
    start = 1'b0;
    $display("ctrl ignore: dones %0d first at %0d dataR %08h", dones, first_done, r);
    check("ignore_done_count", 32'(dones), 32'd1);
    check("ignore_latency", 32'(first_done), 32'd28);
    check("ignore_dataR", r, 32'hC3020000);
    check("ignore_flags", 32'(f), 32'd0);

    // Reset at cycle 10 aborts the operation
    @(negedge clk);
    dataA = 32'h40400000; dataB = 32'h40400000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    $display("ctrl reset: busy %0b dataR %08h flags %03b", busy, dataR, flags);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_dataR", dataR, 32'h0);
    check("abort_flags", 32'(flags), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    do_op(32'h40400000, 32'h40400000, r, f, lat, bc);
    $display("ctrl after reset: %08h flags %03b lat %0d", r, f, lat);
    check("after_reset_latency", 32'(lat), 32'd28);
    check("after_reset_dataR", r, 32'h41100000);

    // Start held high relaunches with 29-cycle spacing
    @(negedge clk);
    dataA = 32'h3FC00000; dataB = 32'h40000000; start = 1'b1;
    first_done = -1; second_done = -1;
    for (int k = 0; k <= 80; k++) begin
      @(posedge clk); #1;
      if (done) begin
        if (first_done < 0) first_done = k;
        else begin second_done = k; break; end
      end
    end
    start = 1'b0;
    r = dataR;
    $display("ctrl held start: done at %0d and %0d dataR %08h", first_done, second_done, r);
    check("held_first_latency", 32'(first_done), 32'd28);
    check("held_spacing", 32'(second_done - first_done), 32'd29);
    check("held_dataR", r, 32'h40400000);
    repeat (35) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/peripheral_fpmul.md
# peripheral_fpmul

Multi-cycle IEEE-754 single-precision multiplier that consumes the two 32-bit operands assembled by the operand-entry peripheral and produces the 32-bit result shown on the seven-segment display path. It sits directly downstream of operand capture and upstream of result display. A start pulse launches one multiply. `done` pulses when `dataR` is valid, and `dataR` holds until the next completion.

## Interface
Parameters:
- `MULT_CYCLES`, default 24: number of shift-add iterations. Fixed at 24 for single precision; other values are unsupported.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (the 0 level resets).
- `start`  in  1  launch request; sampled only in IDLE.
- `dataA`  in  32  operand A (IEEE-754 single precision).
- `dataB`  in  32  operand B (IEEE-754 single precision).
- `busy`  out  1  high from the cycle after start is accepted until `done` is asserted.
- `done`  out  1  one-cycle pulse; `dataR` and `flags` are valid in this cycle.
- `dataR`  out  32  product; registered and held until the next `done`.
- `flags`  out  3  {invalid, overflow, underflow}; registered and held with `dataR`.

## Operation
- Reset (`reset` = 0, asynchronous): state goes to IDLE; `busy`=0, `done`=0, `dataR`=32'h0, `flags`=3'b000; internal registers cleared.
- FSM states: IDLE → UNPACK → MULT → NORM → ROUND → DONE → IDLE.
- **IDLE**
  - `start`=1 latches `dataA`/`dataB` into internal registers and moves to UNPACK.
  - Later changes on `dataA`/`dataB` have no effect on the operation in flight.
- **UNPACK**
  - Split each operand into sign, exponent and mantissa; prepend the hidden 1 (24-bit mantissa).
  - An operand with exponent 0 is treated as ±0 (denormals flushed).
  - Classify special cases: NaN, Inf, zero.
- **MULT**
  - Sequential shift-add, one multiplier bit per cycle, for exactly `MULT_CYCLES` cycles.
  - Produces a 48-bit product `P`.
  - Exponent: `E = eA + eB − 127`, computed as a 10-bit signed value.
- **NORM**
  - If `P[47]`=1: mantissa = `P[46:24]`, guard = `P[23]`, sticky = OR(`P[22:0]`), `E` = `E`+1.
  - Otherwise: mantissa = `P[45:23]`, guard = `P[22]`, sticky = OR(`P[21:0]`).
- **ROUND**
  - Round to nearest, ties to even: increment when guard & (sticky | mantissa LSB).
  - If the increment carries out of the mantissa, set mantissa to 0 and `E` = `E`+1.
- **Result selection, in priority order**
  - Any NaN input, or Inf × 0 → 32'h7FC00000, invalid=1.
  - Inf × nonzero → {sign, 8'hFF, 23'h0}, no flag.
  - Either operand zero → {sign, 31'h0}, no flag.
  - `E` ≥ 255 → {sign, 8'hFF, 23'h0}, overflow=1.
  - `E` ≤ 0 → {sign, 31'h0}, underflow=1.
  - Otherwise → {sign, `E`[7:0], mantissa}.
  - Sign is `sA ^ sB` in every case except NaN.
- **DONE**
  - Register `dataR` and `flags`, pulse `done` for one cycle, clear `busy`, return to IDLE.
- Special-case operands still run the full FSM, so latency is uniform.

## Timing
- `start` is sampled at rising edge N while in IDLE.
- `busy`=1 from N+1 through the cycle before `done`.
- `done`=1 during the cycle following edge N+28; `dataR` and `flags` are updated on that same edge.
- Latency is 28 cycles for all operands, special cases included.
- The earliest next `start` is accepted at the edge that leaves DONE (back-to-back spacing of 29 cycles).
- `start` while `busy`=1 or in DONE is ignored; there is no queueing.
- `start` held high continuously relaunches on every return to IDLE.
- Reset mid-operation: immediate abort; no `done` is produced; `dataR` and `flags` return to 0.

## Test plan
- A=3F800000, B=A1BE867D, `start` pulse → `done` exactly 28 cycles later; `dataR`=A1BE867D, `flags`=000; `busy` high for 27 cycles.
- A=40000000, B=C2820000 → `dataR`=C3020000 (−130.0), `flags`=000.
- Rounding:
  - 3F800001 × 3F800001 → 3F800002.
  - 3FFFFFFF × 3FFFFFFF → 407FFFFE.
  - Both give `flags`=000.
- Range limits:
  - 7F000000 × 7F000000 → 7F800000, `flags`=010.
  - 00800000 × 00800000 → 00000000, `flags`=001.
- Special values:
  - 7F800000 × 00000000 → 7FC00000, `flags`=100.
  - FF800000 × 40000000 → FF800000, `flags`=000.
  - 7FC00000 × 3F800000 → 7FC00000, `flags`=100.
- Control:
  - Second `start` at cycle 5 is ignored; exactly one `done`.
  - Operands changed at cycle 3 do not alter the result.
  - `reset`=0 at cycle 10 → `busy`=0 and `dataR`=0 immediately; no `done`.
  - The next `start` completes normally.
